led_matrix_scan_ctrl: RTL and testbench
=======================================

# led_matrix_scan_ctrl

Row-scan controller for the board's 8x8 LED matrix. It owns the eight row drivers and the eight column drivers, which are the row-select lines and the column lines behind the series resistors. It holds a double-buffered 8x8 frame: user logic writes the back bank while the front bank is displayed. It then requests a swap, which the block performs only at a frame boundary so no frame is ever torn. The block sits between the top level's matrix pins and any producer of pixel data, such as logic driven by the button-flag outputs.

## Interface
- ROW_DIV, 6250: clocks per row slot. The frame is 8*ROW_DIV clocks. Must be ≥ 2.
- BLANK_CYC, 16: dead-time clocks at the start of each row slot, with all drivers off. Must be < ROW_DIV.
- ROW_ON_LVL, 1'b0: logic level that enables a row.
- COL_ON_LVL, 1'b1: logic level that lights a column.
- Reset scheme: one clock; reset is synchronous and active-low.
- clk, in, 1: system clock. All state changes on its rising edge.
- rst_n, in, 1: synchronous active-low reset.
- i_en, in, 1: display enable. When 0, all drivers are off.
- i_wr_en, in, 1: write strobe for the back bank.
- i_wr_row, in, 3: row address of the write.
- i_wr_data, in, 8: pixel bits for that row. Bit c is column c; 1 means lit.
- i_swap_req, in, 1: single-cycle request to swap the banks.
- o_swap_ack, out, 1: one-cycle pulse in the cycle the bank pointer flips.
- o_frame_tick, out, 1: one-cycle pulse when the row index wraps from 7 to 0.
- o_row, out, 8: row drivers, one-hot at ROW_ON_LVL during DRIVE.
- o_col, out, 8: column drivers.

## Operation
- State machine states: IDLE, BLANK, DRIVE.
- IDLE
  - All drivers off; row index = 0; prescaler = 0.
  - Exits to BLANK on the first clock edge that sees i_en = 1.
- BLANK
  - Lasts BLANK_CYC clocks with all drivers off, then moves to DRIVE.
  - If BLANK_CYC = 0, the state is skipped.
- DRIVE
  - Lasts ROW_DIV − BLANK_CYC clocks.
  - o_row bit r is at ROW_ON_LVL; all other row bits are at ~ROW_ON_LVL.
  - o_col[c] = COL_ON_LVL when front[r][c] = 1, otherwise ~COL_ON_LVL.
  - At the end of DRIVE, r advances by 1 (7 wraps to 0) and the state returns to BLANK.
- Drivers-off value: o_row = {8{~ROW_ON_LVL}}, o_col = {8{~COL_ON_LVL}}.
- Writes
  - When i_wr_en = 1, back[i_wr_row] is loaded with i_wr_data.
  - "Back" is the bank pointer value in that same cycle.
  - Writes never alter the bank currently being displayed.
- Swap
  - The swap_pend flag is set by i_swap_req.
  - A boundary occurs on the last DRIVE cycle of row 7, or on any cycle spent in IDLE.
  - At a boundary, if swap_pend or i_swap_req is set: flip the pointer, clear swap_pend, pulse o_swap_ack.
  - Multiple requests before one boundary merge into a single swap and a single ack.
- i_en falling: the block goes to IDLE on the next edge and the drivers are off from that edge. The in-progress row is abandoned.
- A write and a swap in the same cycle: the write lands in the pre-flip back bank, which becomes the front bank.
- Reset
  - Effect: state = IDLE, row = 0, prescaler = 0, pointer = 0, swap_pend = 0, both banks cleared to 0.
  - Outputs: o_swap_ack = 0, o_frame_tick = 0, drivers off.
  - Reset behaves identically when asserted mid-frame.

## Timing
- All outputs are registered and have no combinational path from the inputs.
- i_en 0→1 sampled at edge k: BLANK starts at k; the first DRIVE output of row 0 appears at edge k + BLANK_CYC.
- Row slot: exactly ROW_DIV clocks. Frame: exactly 8*ROW_DIV clocks.
- o_frame_tick and o_swap_ack fall in the same cycle when a swap happens at the row-7 boundary.
- The new front bank is visible from the DRIVE phase of row 0 in the next frame.
- Swap in IDLE: o_swap_ack is asserted one clock after i_swap_req.
- Write-to-display latency: a write becomes visible only after a swap. There is no direct path to the front bank.

## Structure
- Package led_matrix_pkg:
  - state enum {IDLE, BLANK, DRIVE}
  - N_ROWS = 8, N_COLS = 8
  - row index width = 3
- Sub-module led_frame_buf:
  - Two banks of 8x8 bits.
  - One write port to the back bank and one row read port from the front bank.
  - Takes a bank-pointer input and a synchronous active-low clear.
- The top module holds the FSM, prescaler, row counter, swap logic and output registers.

## Test plan
All scenarios use ROW_DIV = 10, BLANK_CYC = 2 and default polarities.
- Reset: hold rst_n = 0 for 3 clocks. Expect o_row = 8'hFF, o_col = 8'h00, both pulses 0. Release with i_en = 0: outputs stay off.
- Basic display
  - Stimulus: write row 3 = 8'hA5, pulse swap, set i_en = 1.
  - Expect an ack within one clock while in IDLE.
  - During the row-3 DRIVE cycles (8 clocks per frame), expect o_row = 8'hF7 and o_col = 8'hA5.
  - Expect o_frame_tick every 80 clocks.
- Mid-frame swap
  - Stimulus: during row 2, write row 0 = 8'h3C, then pulse i_swap_req twice.
  - Expect no change through row 7, exactly one ack coinciding with o_frame_tick, and row 0 showing 8'h3C.
- Back-bank isolation: while the display runs, write all rows = 8'hFF without a swap. Expect displayed o_col unchanged for 3 frames.
- Enable drop
  - Stimulus: drop i_en in the DRIVE phase of row 5.
  - Expect drivers off from the next edge.
  - Re-enable: expect 2 blank clocks, then row 0 (o_row = 8'hFE).
- Reset mid-frame: assert rst_n during row 4. Expect drivers off next edge, and after re-enable plus a swap, all rows show o_col = 8'h00.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared types and sizes for the 8x8 LED matrix row-scan controller.
package led_matrix_pkg;
  localparam int N_ROWS = 8;
  localparam int N_COLS = 8;
  localparam int ROW_W  = 3;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
endpackage

// File: rtl/led_frame_buf.sv
// Double-buffered 8x8 frame: one write port into the back bank (~ptr), one row read port.
// The read bank is chosen by the caller so it can look ahead to the post-swap front bank.
module led_frame_buf
  import led_matrix_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic              ptr,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [N_COLS-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [ROW_W-1:0]  rd_row,
  output logic [N_COLS-1:0] rd_data
);
  logic [N_COLS-1:0] bank [2][N_ROWS];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < N_ROWS; r++)
          bank[b][r] <= '0;
    end else if (wr_en) begin
      bank[~ptr][wr_row] <= wr_data;
    end
  end

  // A write landing in the bank that becomes front on this same edge is forwarded.
  always_comb begin
    rd_data = bank[rd_bank][rd_row];
    if (wr_en && (~ptr == rd_bank) && (wr_row == rd_row))
      rd_data = wr_data;
  end
endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Row-scan controller: blank/drive per row slot, tear-free bank swap at frame boundaries.
// All outputs registered from next-state values, so row r shows exactly BLANK_CYC clocks into its slot.
module led_matrix_scan_ctrl
  import led_matrix_pkg::*;
#(
  parameter int   ROW_DIV    = 6250,
  parameter int   BLANK_CYC  = 16,
  parameter logic ROW_ON_LVL = 1'b0,
  parameter logic COL_ON_LVL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_wr_en,
  input  logic [ROW_W-1:0]  i_wr_row,
  input  logic [N_COLS-1:0] i_wr_data,
  input  logic              i_swap_req,
  output logic              o_swap_ack,
  output logic              o_frame_tick,
  output logic [N_ROWS-1:0] o_row,
  output logic [N_COLS-1:0] o_col
);
  localparam int PW = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;
  localparam logic [PW-1:0] ROW_LAST   = PW'(ROW_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

  state_t            state, state_n;
  logic [ROW_W-1:0]  row, row_n;
  logic [PW-1:0]     presc, presc_n;
  logic              ptr, ptr_n, swap_pend;
  logic              wrap, boundary, do_swap;
  logic [N_COLS-1:0] rd_data;

  assign wrap     = (state == DRIVE) && (row == ROW_W'(N_ROWS - 1)) && (presc == ROW_LAST);
  assign boundary = (state == IDLE) || wrap;
  assign do_swap  = boundary && (swap_pend || i_swap_req);
  assign ptr_n    = ptr ^ do_swap;

  led_frame_buf u_buf (
    .clk     (clk),
    .clr_n   (rst_n),
    .ptr     (ptr),
    .wr_en   (i_wr_en),
    .wr_row  (i_wr_row),
    .wr_data (i_wr_data),
    .rd_bank (ptr_n),
    .rd_row  (row_n),
    .rd_data (rd_data)
  );

  always_comb begin
    state_n = state;
    row_n   = row;
    presc_n = presc;
    if (!i_en) begin
      state_n = IDLE;
      row_n   = '0;
      presc_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = (BLANK_CYC == 0) ? DRIVE : BLANK;
          row_n   = '0;
          presc_n = '0;
        end
        BLANK: begin
          presc_n = presc + PW'(1);
          if (presc == BLANK_LAST) state_n = DRIVE;
        end
        DRIVE: begin
          if (presc == ROW_LAST) begin
            presc_n = '0;
            row_n   = row + ROW_W'(1);
            state_n = (BLANK_CYC == 0) ? DRIVE : BLANK;
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      row          <= '0;
      presc        <= '0;
      ptr          <= 1'b0;
      swap_pend    <= 1'b0;
      o_swap_ack   <= 1'b0;
      o_frame_tick <= 1'b0;
      o_row        <= {N_ROWS{~ROW_ON_LVL}};
      o_col        <= {N_COLS{~COL_ON_LVL}};
    end else begin
      state        <= state_n;
      row          <= row_n;
      presc        <= presc_n;
      ptr          <= ptr_n;
      swap_pend    <= do_swap ? 1'b0 : (swap_pend | i_swap_req);
      o_swap_ack   <= do_swap;
      o_frame_tick <= wrap && i_en;
      if (state_n == DRIVE) begin
        o_row <= {N_ROWS{~ROW_ON_LVL}} ^ (N_ROWS'(1) << row_n);
        o_col <= {N_COLS{~COL_ON_LVL}} ^ rd_data;
      end else begin
        o_row <= {N_ROWS{~ROW_ON_LVL}};
        o_col <= {N_COLS{~COL_ON_LVL}};
      end
    end
  end
endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Directed bench for led_matrix_scan_ctrl with ROW_DIV=10, BLANK_CYC=2 (row r drives slot cycles 2..9).
module tb_led_matrix_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, i_en, i_wr_en, i_swap_req;
  logic [2:0] i_wr_row;
  logic [7:0] i_wr_data;
  logic       o_swap_ack, o_frame_tick;
  logic [7:0] o_row, o_col;
  int checks = 0;
  int errors = 0;

  led_matrix_scan_ctrl #(.ROW_DIV(10), .BLANK_CYC(2), .ROW_ON_LVL(1'b0), .COL_ON_LVL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_wr_en(i_wr_en), .i_wr_row(i_wr_row),
    .i_wr_data(i_wr_data), .i_swap_req(i_swap_req), .o_swap_ack(o_swap_ack),
    .o_frame_tick(o_frame_tick), .o_row(o_row), .o_col(o_col)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] er;
    rst_n = 1'b0; i_en = 1'b0; i_wr_en = 1'b0; i_swap_req = 1'b0;
    i_wr_row = '0; i_wr_data = '0;

    // Reset
    cyc(3);
    chk("rst_row", o_row, 8'hFF);
    chk("rst_col", o_col, 8'h00);
    chk("rst_ack", {7'd0, o_swap_ack}, 8'h00);
    chk("rst_tick", {7'd0, o_frame_tick}, 8'h00);
    rst_n = 1'b1;
    cyc(2);
    chk("idle_row", o_row, 8'hFF);
    chk("idle_col", o_col, 8'h00);

    // Basic display: write row 3, swap in IDLE, enable
    i_wr_en = 1'b1; i_wr_row = 3'd3; i_wr_data = 8'hA5;
    cyc(1);
    i_wr_en = 1'b0; i_swap_req = 1'b1;
    cyc(1);
    chk("idle_ack", {7'd0, o_swap_ack}, 8'h01);
    i_swap_req = 1'b0; i_en = 1'b1;
    cyc(1);                                  // edge k: BLANK
    chk("ack_fall", {7'd0, o_swap_ack}, 8'h00);
    chk("blank0_row", o_row, 8'hFF);
    cyc(1);
    chk("blank1_row", o_row, 8'hFF);
    cyc(1);                                  // k+2: row 0 drive
    chk("r0_row", o_row, 8'hFE);
    chk("r0_col", o_col, 8'h00);
    cyc(30);                                 // k+32
    chk("r3_row_first", o_row, 8'hF7);
    chk("r3_col_first", o_col, 8'hA5);
    cyc(7);                                  // k+39
    chk("r3_row_last", o_row, 8'hF7);
    chk("r3_col_last", o_col, 8'hA5);
    cyc(1);                                  // k+40: row 4 blank
    chk("r4_blank_row", o_row, 8'hFF);
    chk("r4_blank_col", o_col, 8'h00);
    cyc(39);                                 // k+79
    chk("r7_row", o_row, 8'h7F);
    chk("tick_pre", {7'd0, o_frame_tick}, 8'h00);
    cyc(1);                                  // k+80
    chk("tick1", {7'd0, o_frame_tick}, 8'h01);
    chk("tick1_row", o_row, 8'hFF);
    cyc(1);
    chk("tick1_fall", {7'd0, o_frame_tick}, 8'h00);
    cyc(79);                                 // k+160 = F
    chk("tick2", {7'd0, o_frame_tick}, 8'h01);
    chk("tick2_noack", {7'd0, o_swap_ack}, 8'h00);

    // Mid-frame swap: write row 0 during row 2, two merged requests
    cyc(21);                                 // F+21
    i_wr_en = 1'b1; i_wr_row = 3'd0; i_wr_data = 8'h3C;
    cyc(1);
    i_wr_en = 1'b0; i_swap_req = 1'b1;
    cyc(1);
    i_swap_req = 1'b0;
    cyc(1);
    i_swap_req = 1'b1;
    cyc(1);                                  // F+25
    i_swap_req = 1'b0;
    chk("mid_noack", {7'd0, o_swap_ack}, 8'h00);
    cyc(7);                                  // F+32: row 3 still old front
    chk("mid_r3_col", o_col, 8'hA5);
    cyc(40);                                 // F+72
    chk("mid_r7_row", o_row, 8'h7F);
    chk("mid_r7_ack", {7'd0, o_swap_ack}, 8'h00);
    cyc(7);                                  // F+79
    chk("mid_pre_ack", {7'd0, o_swap_ack}, 8'h00);
    cyc(1);                                  // F+80
    chk("swap_ack", {7'd0, o_swap_ack}, 8'h01);
    chk("swap_tick", {7'd0, o_frame_tick}, 8'h01);
    cyc(1);
    chk("swap_ack_fall", {7'd0, o_swap_ack}, 8'h00);
    cyc(1);                                  // F+82
    chk("new_r0_row", o_row, 8'hFE);
    chk("new_r0_col", o_col, 8'h3C);
    cyc(30);                                 // F+112
    chk("new_r3_row", o_row, 8'hF7);
    chk("new_r3_col", o_col, 8'h00);
    cyc(48);                                 // F+160 = G
    chk("single_ack", {7'd0, o_swap_ack}, 8'h00);
    chk("tick3", {7'd0, o_frame_tick}, 8'h01);

    // Back-bank isolation: fill back bank with FF, no swap
    for (int r = 0; r < 8; r++) begin
      i_wr_en = 1'b1; i_wr_row = 3'(r); i_wr_data = 8'hFF;
      cyc(1);
    end
    i_wr_en = 1'b0;                          // G+8
    cyc(1);                                  // G+9
    chk("iso_r0_now", o_col, 8'h3C);
    cyc(73);                                 // G+82
    for (int f = 0; f < 3; f++) begin
      chk("iso_r0_row", o_row, 8'hFE);
      chk("iso_r0_col", o_col, 8'h3C);
      cyc(30);
      chk("iso_r3_col", o_col, 8'h00);
      cyc(50);
    end                                      // H+2, H = G+320

    // Enable drop during row 5 drive
    cyc(52);                                 // H+54
    chk("en_r5_row", o_row, 8'hDF);
    i_en = 1'b0;
    cyc(1);
    chk("en_off_row", o_row, 8'hFF);
    chk("en_off_col", o_col, 8'h00);
    cyc(3);
    chk("en_off_row_hold", o_row, 8'hFF);
    i_en = 1'b1;
    cyc(1);
    chk("reen_blank0", o_row, 8'hFF);
    cyc(1);
    chk("reen_blank1", o_row, 8'hFF);
    cyc(1);
    chk("reen_r0_row", o_row, 8'hFE);
    chk("reen_r0_col", o_col, 8'h3C);
    chk("reen_noack", {7'd0, o_swap_ack}, 8'h00);

    // Reset mid-frame during row 4
    cyc(42);
    chk("pre_rst_r4", o_row, 8'hEF);
    rst_n = 1'b0;
    cyc(1);
    chk("midrst_row", o_row, 8'hFF);
    chk("midrst_col", o_col, 8'h00);
    chk("midrst_tick", {7'd0, o_frame_tick}, 8'h00);
    rst_n = 1'b1; i_en = 1'b0;
    cyc(1);
    i_swap_req = 1'b1;
    cyc(1);
    chk("midrst_ack", {7'd0, o_swap_ack}, 8'h01);
    i_swap_req = 1'b0; i_en = 1'b1;
    cyc(3);
    for (int r = 0; r < 8; r++) begin
      er = ~(8'd1 << r);
      chk("clr_row", o_row, er);
      chk("clr_col", o_col, 8'h00);
      cyc(10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
